// File: rtl/lab2_cmd_parser_if.sv
// Command-parser bus: UART RX byte stream and adder handshake in, parsed
// operands / strobes out. The parser sits on the slave modport; whatever
// feeds it (UART RX plus adder stage) uses the master modport.
interface lab2_cmd_parser_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       i_result_rdy;
    logic [7:0] o_r1;
    logic [7:0] o_r2;
    logic       o_substract;
    logic       o_data_rdy;
    logic       o_busy;
    logic       o_err;
    logic [7:0] o_echo_data;
    logic       o_echo_valid;

    modport master (
        output i_rx_data, i_rx_valid, i_result_rdy,
        input  o_r1, o_r2, o_substract, o_data_rdy, o_busy, o_err,
        input  o_echo_data, o_echo_valid
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_result_rdy,
        output o_r1, o_r2, o_substract, o_data_rdy, o_busy, o_err,
        output o_echo_data, o_echo_valid
    );
endinterface

// File: rtl/lab2_cmd_parser.sv
// Lab2 command parser: turns "<digit><op><digit><term>" byte streams into
// operand chars, subtract flag and a one-cycle data-ready strobe for the hex
// adder, then holds off until the adder answers or a timeout expires.
// Optional echo of accepted characters is enabled with `define PARSER_ECHO_EN.
module lab2_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    lab2_cmd_parser_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPER  = 3'd1,
        S_OP2   = 3'd2,
        S_TERM  = 3'd3,
        S_ISSUE = 3'd4,
        S_WAIT  = 3'd5
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Uppercase A-F is accepted alongside 0-9 and a-f.
    function automatic logic is_digit(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h61) && (b <= 8'h66)) ||
               ((b >= 8'h41) && (b <= 8'h46));
    endfunction

    // Operands are always stored lowercase so the adder sees one char set.
    function automatic logic [7:0] to_lower(input logic [7:0] b);
        return ((b >= 8'h41) && (b <= 8'h46)) ? (b + 8'h20) : b;
    endfunction

    function automatic logic is_op(input logic [7:0] b);
        return (b == 8'h2B) || (b == 8'h2D);
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == 8'h3D) || (b == 8'h0D);
    endfunction

    state_t     state_r, state_nxt_s;
    logic [7:0] cnt_r, cnt_nxt_s;
    logic       ld_r1_s, ld_r2_s, ld_sub_s, set_err_s, clr_err_s, echo_s;
    logic       space_s, esc_s;
    logic [7:0] r1_r, r2_r;
    logic       sub_r, data_rdy_r, busy_r, err_r;

    assign space_s = bus.i_rx_valid && (bus.i_rx_data == 8'h20);
    assign esc_s   = bus.i_rx_valid && (bus.i_rx_data == 8'h1B);

    // State and timeout counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state decode and per-byte load/error/echo controls.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ld_r1_s     = 1'b0;
        ld_r2_s     = 1'b0;
        ld_sub_s    = 1'b0;
        set_err_s   = 1'b0;
        clr_err_s   = 1'b0;
        echo_s      = 1'b0;
        case (state_r)
            S_IDLE, S_OPER, S_OP2, S_TERM: begin
                if (!bus.i_rx_valid || space_s) begin
                    state_nxt_s = state_r;
                end else if (esc_s) begin
                    state_nxt_s = S_IDLE;
                end else if ((state_r == S_IDLE) && is_digit(bus.i_rx_data)) begin
                    ld_r1_s     = 1'b1;
                    clr_err_s   = 1'b1;
                    echo_s      = 1'b1;
                    state_nxt_s = S_OPER;
                end else if ((state_r == S_OPER) && is_op(bus.i_rx_data)) begin
                    ld_sub_s    = 1'b1;
                    echo_s      = 1'b1;
                    state_nxt_s = S_OP2;
                end else if ((state_r == S_OP2) && is_digit(bus.i_rx_data)) begin
                    ld_r2_s     = 1'b1;
                    echo_s      = 1'b1;
                    state_nxt_s = S_TERM;
                end else if ((state_r == S_TERM) && is_term(bus.i_rx_data)) begin
                    echo_s      = 1'b1;
                    state_nxt_s = S_ISSUE;
                end else begin
                    set_err_s   = 1'b1;
                    state_nxt_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_nxt_s = S_WAIT;
                cnt_nxt_s   = 8'd0;
            end
            S_WAIT: begin
                // Adder answer beats a simultaneous timeout; ESC aborts quietly.
                if (bus.i_result_rdy) begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = 8'd0;
                end else if (esc_s) begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = 8'd0;
                end else if (cnt_r == CNT_LAST) begin
                    set_err_s   = 1'b1;
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s   = cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // Registered outputs; strobe and busy are derived from the next state so
    // they line up with the ISSUE/WAIT cycles themselves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_r       <= 8'h00;
            r2_r       <= 8'h00;
            sub_r      <= 1'b0;
            data_rdy_r <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (ld_r1_s) r1_r <= to_lower(bus.i_rx_data);
            if (ld_r2_s) r2_r <= to_lower(bus.i_rx_data);
            if (ld_sub_s) sub_r <= (bus.i_rx_data == 8'h2D);
            data_rdy_r <= (state_nxt_s == S_ISSUE);
            busy_r     <= (state_nxt_s == S_ISSUE) || (state_nxt_s == S_WAIT);
            if (set_err_s) begin
                err_r <= 1'b1;
            end else if (clr_err_s) begin
                err_r <= 1'b0;
            end
        end
    end

    assign bus.o_r1        = r1_r;
    assign bus.o_r2        = r2_r;
    assign bus.o_substract = sub_r;
    assign bus.o_data_rdy  = data_rdy_r;
    assign bus.o_busy      = busy_r;
    assign bus.o_err       = err_r;

`ifdef PARSER_ECHO_EN
    logic [7:0] echo_data_r;
    logic       echo_valid_r;

    // Echo accepted characters exactly as received, one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_data_r  <= 8'h00;
            echo_valid_r <= 1'b0;
        end else begin
            echo_valid_r <= echo_s;
            if (echo_s) echo_data_r <= bus.i_rx_data;
        end
    end

    assign bus.o_echo_data  = echo_data_r;
    assign bus.o_echo_valid = echo_valid_r;
`else
    logic unused_echo_s;
    assign unused_echo_s    = echo_s;
    assign bus.o_echo_data  = 8'h00;
    assign bus.o_echo_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lab2_cmd_parser.sv
// Directed bench for lab2_cmd_parser. Echo expectations follow PARSER_ECHO_EN.
module tb_lab2_cmd_parser;

    localparam int TO = 64;
`ifdef PARSER_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    lab2_cmd_parser_if bus();

    lab2_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one byte for one cycle; returns on the negedge after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
    endtask

    task automatic pulse_result_rdy();
        bus.i_result_rdy = 1'b1;
        @(negedge clk);
        bus.i_result_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.o_r1 !== 8'h00) begin n_fail++; $display("FAIL reset_r1: got %h want 00", bus.o_r1); end
        n_cmp++; if (bus.o_r2 !== 8'h00) begin n_fail++; $display("FAIL reset_r2: got %h want 00", bus.o_r2); end
        n_cmp++; if ({bus.o_substract, bus.o_data_rdy, bus.o_busy, bus.o_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.o_substract, bus.o_data_rdy, bus.o_busy, bus.o_err}); end
        n_cmp++; if ({bus.o_echo_valid, bus.o_echo_data} !== 9'h000) begin n_fail++; $display("FAIL reset_echo: got %h want 000", {bus.o_echo_valid, bus.o_echo_data}); end
    endtask

    task automatic test_add();
        send_byte(8'h33);
        send_byte(8'h2B);
        send_byte(8'h34);
        n_cmp++; if ({bus.o_data_rdy, bus.o_busy} !== 2'b00) begin n_fail++; $display("FAIL add_pre_term: got %b want 00", {bus.o_data_rdy, bus.o_busy}); end
        send_byte(8'h3D);
        n_cmp++; if (bus.o_data_rdy !== 1'b1) begin n_fail++; $display("FAIL add_data_rdy: got %b want 1", bus.o_data_rdy); end
        n_cmp++; if (bus.o_r1 !== 8'h33) begin n_fail++; $display("FAIL add_r1: got %h want 33", bus.o_r1); end
        n_cmp++; if (bus.o_r2 !== 8'h34) begin n_fail++; $display("FAIL add_r2: got %h want 34", bus.o_r2); end
        n_cmp++; if ({bus.o_substract, bus.o_busy} !== 2'b01) begin n_fail++; $display("FAIL add_sub_busy: got %b want 01", {bus.o_substract, bus.o_busy}); end
        n_cmp++; if (bus.o_echo_valid !== ECHO || bus.o_echo_data !== (ECHO ? 8'h3D : 8'h00)) begin n_fail++; $display("FAIL add_echo: got %b/%h want %b/%h", bus.o_echo_valid, bus.o_echo_data, ECHO, ECHO ? 8'h3D : 8'h00); end
        @(negedge clk);
        n_cmp++; if ({bus.o_data_rdy, bus.o_busy} !== 2'b01) begin n_fail++; $display("FAIL add_strobe_end: got %b want 01", {bus.o_data_rdy, bus.o_busy}); end
        repeat (3) @(negedge clk);
        pulse_result_rdy();
        n_cmp++; if ({bus.o_busy, bus.o_err, bus.o_data_rdy} !== 3'b000) begin n_fail++; $display("FAIL add_done: got %b want 000", {bus.o_busy, bus.o_err, bus.o_data_rdy}); end
        n_cmp++; if (bus.o_r1 !== 8'h33) begin n_fail++; $display("FAIL add_r1_hold: got %h want 33", bus.o_r1); end
    endtask

    task automatic test_sub_upper();
        send_byte(8'h41);
        n_cmp++; if (bus.o_echo_valid !== ECHO || bus.o_echo_data !== (ECHO ? 8'h41 : 8'h00)) begin n_fail++; $display("FAIL sub_echo_A: got %b/%h want %b", bus.o_echo_valid, bus.o_echo_data, ECHO); end
        send_byte(8'h2D);
        n_cmp++; if (bus.o_echo_valid !== ECHO || bus.o_echo_data !== (ECHO ? 8'h2D : 8'h00)) begin n_fail++; $display("FAIL sub_echo_minus: got %b/%h want %b", bus.o_echo_valid, bus.o_echo_data, ECHO); end
        send_byte(8'h20);
        n_cmp++; if ({bus.o_echo_valid, bus.o_err} !== 2'b00) begin n_fail++; $display("FAIL sub_space: got %b want 00", {bus.o_echo_valid, bus.o_err}); end
        send_byte(8'h66);
        n_cmp++; if (bus.o_echo_valid !== ECHO || bus.o_echo_data !== (ECHO ? 8'h66 : 8'h00)) begin n_fail++; $display("FAIL sub_echo_f: got %b/%h want %b", bus.o_echo_valid, bus.o_echo_data, ECHO); end
        send_byte(8'h0D);
        n_cmp++; if (bus.o_echo_valid !== ECHO || bus.o_echo_data !== (ECHO ? 8'h0D : 8'h00)) begin n_fail++; $display("FAIL sub_echo_cr: got %b/%h want %b", bus.o_echo_valid, bus.o_echo_data, ECHO); end
        n_cmp++; if (bus.o_data_rdy !== 1'b1) begin n_fail++; $display("FAIL sub_data_rdy: got %b want 1", bus.o_data_rdy); end
        n_cmp++; if (bus.o_r1 !== 8'h61) begin n_fail++; $display("FAIL sub_r1_lower: got %h want 61", bus.o_r1); end
        n_cmp++; if (bus.o_r2 !== 8'h66) begin n_fail++; $display("FAIL sub_r2: got %h want 66", bus.o_r2); end
        n_cmp++; if (bus.o_substract !== 1'b1) begin n_fail++; $display("FAIL sub_flag: got %b want 1", bus.o_substract); end
        @(negedge clk);
        n_cmp++; if ({bus.o_data_rdy, bus.o_echo_valid} !== 2'b00) begin n_fail++; $display("FAIL sub_one_pulse: got %b want 00", {bus.o_data_rdy, bus.o_echo_valid}); end
        pulse_result_rdy();
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL sub_done: got %b want 0", bus.o_busy); end
    endtask

    task automatic test_error();
        send_byte(8'h35);
        send_byte(8'h2A);
        n_cmp++; if ({bus.o_err, bus.o_busy, bus.o_data_rdy} !== 3'b100) begin n_fail++; $display("FAIL err_set: got %b want 100", {bus.o_err, bus.o_busy, bus.o_data_rdy}); end
        send_byte(8'h32);
        n_cmp++; if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", bus.o_err); end
        n_cmp++; if (bus.o_r1 !== 8'h32) begin n_fail++; $display("FAIL err_r1: got %h want 32", bus.o_r1); end
        send_byte(8'h1B);
    endtask

    task automatic test_timeout();
        int wc;
        send_byte(8'h31);
        send_byte(8'h2B);
        send_byte(8'h31);
        send_byte(8'h3D);
        wc = 0;
        for (int i = 0; i < 300; i++) begin
            bus.i_rx_data  = 8'h39;
            bus.i_rx_valid = ((wc % 16) == 5);
            @(negedge clk);
            if (bus.o_busy) wc++;
            else break;
        end
        bus.i_rx_valid = 1'b0;
        n_cmp++; if (wc !== TO) begin n_fail++; $display("FAIL to_wait_cycles: got %0d want %0d", wc, TO); end
        n_cmp++; if ({bus.o_err, bus.o_busy, bus.o_data_rdy} !== 3'b100) begin n_fail++; $display("FAIL to_flags: got %b want 100", {bus.o_err, bus.o_busy, bus.o_data_rdy}); end
        n_cmp++; if (bus.o_r1 !== 8'h31) begin n_fail++; $display("FAIL to_r1_hold: got %h want 31", bus.o_r1); end
    endtask

    task automatic test_esc();
        send_byte(8'h1B);
        n_cmp++; if (bus.o_err !== 1'b1) begin n_fail++; $display("FAIL esc_err_kept: got %b want 1", bus.o_err); end
        send_byte(8'h37);
        send_byte(8'h2B);
        send_byte(8'h1B);
        n_cmp++; if ({bus.o_err, bus.o_busy, bus.o_data_rdy, bus.o_echo_valid} !== 4'b0000) begin n_fail++; $display("FAIL esc_abort: got %b want 0000", {bus.o_err, bus.o_busy, bus.o_data_rdy, bus.o_echo_valid}); end
        send_byte(8'h34);
        n_cmp++; if ({bus.o_r1, bus.o_err} !== {8'h34, 1'b0}) begin n_fail++; $display("FAIL esc_idle: got %h want 068", {bus.o_r1, bus.o_err}); end
        send_byte(8'h1B);
    endtask

    task automatic test_rst_mid();
        send_byte(8'h37);
        send_byte(8'h2B);
        send_byte(8'h38);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({bus.o_r1, bus.o_r2} !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_ops: got %h want 0000", {bus.o_r1, bus.o_r2}); end
        n_cmp++; if ({bus.o_substract, bus.o_data_rdy, bus.o_busy, bus.o_err, bus.o_echo_valid} !== 5'b00000) begin n_fail++; $display("FAIL rst_mid_flags: got %b want 00000", {bus.o_substract, bus.o_data_rdy, bus.o_busy, bus.o_err, bus.o_echo_valid}); end
        send_byte(8'h3D);
        n_cmp++; if ({bus.o_err, bus.o_data_rdy, bus.o_busy} !== 3'b100) begin n_fail++; $display("FAIL rst_mid_term: got %b want 100", {bus.o_err, bus.o_data_rdy, bus.o_busy}); end
    endtask

    task automatic test_race();
        send_byte(8'h31);
        send_byte(8'h2B);
        send_byte(8'h32);
        send_byte(8'h3D);
        repeat (TO) @(negedge clk);
        n_cmp++; if ({bus.o_busy, bus.o_err} !== 2'b10) begin n_fail++; $display("FAIL race_still_wait: got %b want 10", {bus.o_busy, bus.o_err}); end
        pulse_result_rdy();
        n_cmp++; if ({bus.o_busy, bus.o_err} !== 2'b00) begin n_fail++; $display("FAIL race_rdy_wins: got %b want 00", {bus.o_busy, bus.o_err}); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.i_rx_data = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_result_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub_upper();
        test_error();
        test_timeout();
        test_esc();
        test_rst_mid();
        test_race();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
